// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared types and helpers for the MEM-stage SRAM controller.
//   - state_t       : access sequencer states (IDLE -> LO -> HI -> DONE)
//   - HALF_LO/HI    : half-word select placed in the SRAM address LSB
//   - word_index()  : byte address -> 32-bit word index relative to a base
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Word index of a byte address; arithmetic wraps modulo 2^32, bits [1:0] drop out.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] w_off;
    w_off = addr - base;
    return w_off >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
//   Wait-state counter running 0..WAIT_CYCLES-1 and wrapping to 0.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : synchronous active-low reset
//     i_clr   : force count to 0 (has priority over i_en)
//     i_en    : advance the count
//     o_cnt   : current count
//     o_last  : count equals WAIT_CYCLES-1
// -----------------------------------------------------------------------------
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LastVal);

endmodule

// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
//   MEM-stage sequencer for a 16-bit off-chip SRAM. Each 32-bit load/store is
//   split into a low and a high half-word access, each held on the bus for
//   WAIT_CYCLES cycles. 'freeze' stalls IF..EXE while an access is pending.
//
//   Optional feature macro: WRITE_POST_EN
//     defined   : one-entry posted write buffer; a store in IDLE completes
//                 immediately (ready=1 that cycle) and drains in the background.
//     undefined : stores take the full latency like loads.
//
//   Ports:
//     clk         : clock, rising edge
//     rst         : synchronous active-low reset
//     rd_en/wr_en : load / store request (store wins when both set)
//     address     : byte address, bits [1:0] ignored
//     wdata       : store data
//     rdata       : load data, valid while ready=1 after a read; held otherwise
//     ready       : access complete this cycle
//     freeze      : (rd_en|wr_en) & ~ready
//     sram_addr   : half-word address {word, half}
//     sram_wdata  : write half
//     sram_rdata  : read half from SRAM
//     sram_we_n   : active-low write strobe
//     sram_oe_n   : active-low output enable
// -----------------------------------------------------------------------------
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned WordW    = SRAM_AW - 1;
  localparam int unsigned CntW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);
  // With a single wait cycle there is no room for a strobe ahead of the hold cycle.
  localparam logic        WeFirst  = (WAIT_CYCLES > 1);

  state_t             r_state;
  logic               r_is_wr;
  logic [WordW-1:0]   r_word;
  logic [15:0]        r_wdata_hi;
  logic [31:0]        r_rdata;
  logic               r_ready;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [15:0]        r_sram_wdata;
  logic               r_we_n;
  logic               r_oe_n;

  logic [WordW-1:0]   w_word;
  logic [CntW-1:0]    w_cnt;
  logic               w_last;
  logic               w_cnt_en;
  logic               w_cnt_clr;
  logic               w_req;
  logic               w_we_mid;

  assign w_word    = WordW'(word_index(address, BaseAddr));
  assign w_req     = rd_en | wr_en;
  assign w_cnt_en  = (r_state == LO) || (r_state == HI);
  assign w_cnt_clr = !w_cnt_en;

  // Strobe for the next cycle within a half: low unless that cycle is the final hold cycle.
  assign w_we_mid  = r_is_wr && ((32'(w_cnt) + 32'd2) < WAIT_CYCLES);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CntW)
  ) u_wait_counter (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );

  // Bus outputs are registered and set up one edge ahead of the cycle they apply to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_is_wr      <= 1'b0;
      r_word       <= '0;
      r_wdata_hi   <= '0;
      r_rdata      <= '0;
      r_ready      <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state      <= LO;
            r_is_wr      <= wr_en;
            r_word       <= w_word;
            r_wdata_hi   <= wdata[31:16];
            r_sram_addr  <= {w_word, HALF_LO};
            r_sram_wdata <= wdata[15:0];
            r_oe_n       <= wr_en;
            r_we_n       <= !(wr_en && WeFirst);
          end
        end
        LO: begin
          if (w_last) begin
            if (!r_is_wr) begin
              r_rdata[15:0] <= sram_rdata;
            end
            r_state      <= HI;
            r_sram_addr  <= {r_word, HALF_HI};
            r_sram_wdata <= r_wdata_hi;
            r_we_n       <= !(r_is_wr && WeFirst);
          end else begin
            r_we_n <= !w_we_mid;
          end
        end
        HI: begin
          if (w_last) begin
            if (!r_is_wr) begin
              r_rdata[31:16] <= sram_rdata;
            end
            r_state <= DONE;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
`ifdef WRITE_POST_EN
            // A posted store already reported completion when it was accepted.
            r_ready <= !r_is_wr;
`else
            r_ready <= 1'b1;
`endif
          end else begin
            r_we_n <= !w_we_mid;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef WRITE_POST_EN
  // A store accepted in IDLE is buffered, so the pipeline may advance at once.
  assign ready = r_ready | ((r_state == IDLE) & wr_en);
`else
  assign ready = r_ready;
`endif

  assign freeze     = w_req & ~ready;
  assign rdata      = r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;

endmodule
